// File: rtl/bk_pkg.sv
// Shared types and helpers for the Brent-Kung prefix network: generate/propagate
// pairs, the group combine operator and tree-node index predicates.
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Combines a more-significant group (hi) with the adjacent less-significant group (lo).
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic int node_span(input int level);
        return 1 << level;
    endfunction

    // Up-sweep node at this level: idx closes a group of node_span(level) bits.
    function automatic logic is_up_node(input int level, input int idx);
        return ((idx + 1) % node_span(level)) == 0;
    endfunction

    // Down-sweep node for a given stride: an odd multiple (>= 3) of stride, minus one.
    function automatic logic is_down_node(input int stride, input int idx);
        return (((idx + 1) % (2 * stride)) == stride) && (idx >= 3 * stride - 1);
    endfunction

endpackage

// File: rtl/bk_pipe_stage.sv
// Generic valid/ready register slice; accepts when empty or when downstream takes
// the current entry in the same cycle.
module bk_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Three-stage pipelined subtractor diff = a - b - bin, computed as a + ~b + ~bin
// through a Brent-Kung prefix network split into up-sweep and down-sweep stages.
module brent_kung_sub_pipe #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         ovf
);
    import bk_pkg::*;

    localparam int LEVELS = $clog2(N);
    localparam int TW     = (LEVELS + 1) * N * 2;
    localparam int W1     = 2 * N + 3;
    localparam int W2     = TW + 3;
    localparam int W3     = N + 2;

    logic [W1-1:0] s1_d, s1_q;
    logic [W2-1:0] s2_d, s2_q;
    logic [W3-1:0] s3_d, s3_q;
    logic          s1_v, s2_v, s2_rdy, s3_rdy;

    // Stage 1 payload: carry-in, operand sign bits, bitwise generate/propagate of a + ~b.
    assign s1_d = {~bin, a[N-1], b[N-1], a & ~b, a ^ ~b};

    logic         s1_cin, s1_as, s1_bs;
    logic [N-1:0] s1_g, s1_p;
    assign s1_cin = s1_q[2*N+2];
    assign s1_as  = s1_q[2*N+1];
    assign s1_bs  = s1_q[2*N];
    assign s1_g   = s1_q[2*N-1:N];
    assign s1_p   = s1_q[N-1:0];

    gp_t [LEVELS:0][N-1:0] up_tree;

    // Non-node positions copy the level below so every level is a complete row.
    always_comb begin
        up_tree = '0;
        for (int i = 0; i < N; i++) begin
            up_tree[0][i].g = s1_g[i];
            up_tree[0][i].p = s1_p[i];
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                if (is_up_node(l, i)) begin
                    up_tree[l][i] = gp_combine(up_tree[l-1][i],
                        up_tree[l-1][(i >= node_span(l-1)) ? i - node_span(l-1) : 0]);
                end else begin
                    up_tree[l][i] = up_tree[l-1][i];
                end
            end
        end
    end

    assign s2_d = {s1_cin, s1_as, s1_bs, up_tree};

    logic                  s2_cin, s2_as, s2_bs;
    gp_t [LEVELS:0][N-1:0] s2_tree;
    assign s2_cin  = s2_q[TW+2];
    assign s2_as   = s2_q[TW+1];
    assign s2_bs   = s2_q[TW];
    assign s2_tree = s2_q[TW-1:0];

    // Only the tree nodes feed the down-sweep; pass-through copies are left to synthesis.
    logic unused_tree;
    assign unused_tree = ^s2_tree;

    gp_t [N-1:0]  pr;
    logic [N:0]   c;
    logic [N-1:0] dsum;
    logic         s3_ovf;

    // Top row already holds prefixes at 2^k-1; fill the rest from coarse to fine stride.
    always_comb begin
        pr = s2_tree[LEVELS];
        for (int d = LEVELS - 2; d >= 0; d--) begin
            for (int i = 0; i < N; i++) begin
                if (is_down_node(node_span(d), i)) begin
                    pr[i] = gp_combine(s2_tree[d][i],
                        pr[(i >= node_span(d)) ? i - node_span(d) : 0]);
                end
            end
        end
        c    = '0;
        dsum = '0;
        c[0] = s2_cin;
        for (int i = 0; i < N; i++) begin
            c[i+1]  = pr[i].g | (pr[i].p & s2_cin);
            dsum[i] = s2_tree[0][i].p ^ c[i];
        end
    end

    assign s3_ovf = (s2_as != s2_bs) && (dsum[N-1] != s2_as);
    assign s3_d   = {s3_ovf, ~c[N], dsum};
    assign {ovf, borrow_out, diff} = s3_q;

    bk_pipe_stage #(.W(W1)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (s1_v),
        .out_data  (s1_q),
        .out_ready (s2_rdy)
    );

    bk_pipe_stage #(.W(W2)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_v),
        .in_ready  (s2_rdy),
        .in_data   (s2_d),
        .out_valid (s2_v),
        .out_data  (s2_q),
        .out_ready (s3_rdy)
    );

    bk_pipe_stage #(.W(W3)) u_s3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s2_v),
        .in_ready  (s3_rdy),
        .in_data   (s3_d),
        .out_valid (out_valid),
        .out_data  (s3_q),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Directed and randomized checks for the pipelined Brent-Kung subtractor.
module tb_brent_kung_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        borrow_out;
    logic        ovf;

    int          n_checks = 0;
    int          n_err    = 0;

    logic [65:0] exp_q[$];
    logic [65:0] e;
    int          sent, got, cyc;

    brent_kung_sub_pipe #(.N(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] x, input logic [63:0] y, input logic c);
        a        = x;
        b        = y;
        bin      = c;
        in_valid = 1'b1;
    endtask

    // Reference: {ovf, borrow, diff}
    function automatic logic [65:0] ref_sub(input logic [63:0] x, input logic [63:0] y,
                                            input logic c);
        logic [64:0] t;
        t = {1'b0, x} - {1'b0, y} - {64'd0, c};
        return {(x[63] != y[63]) && (t[63] != x[63]), t[64], t[63:0]};
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_ovf", ovf, 0);
        #10 rst_n = 1'b1;
        tick();

        // 0 - 0 - 0 with latency check
        drive(64'd0, 64'd0, 1'b0);
        #1 chk("t1_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t1_lat_a", out_valid, 0);
        tick();
        chk("t1_lat_b", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_diff", diff, 64'd0);
        chk("t1_borrow", borrow_out, 0);
        chk("t1_ovf", ovf, 0);
        tick();
        chk("t1_drained", out_valid, 0);

        // Back-to-back: 0-1 then 510-255
        drive(64'd0, 64'd1, 1'b0);
        tick();
        drive(64'd510, 64'd255, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t2a_valid", out_valid, 1);
        chk("t2a_diff", diff, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2a_borrow", borrow_out, 1);
        chk("t2a_ovf", ovf, 0);
        tick();
        chk("t2b_valid", out_valid, 1);
        chk("t2b_diff", diff, 64'd255);
        chk("t2b_borrow", borrow_out, 0);
        chk("t2b_ovf", ovf, 0);
        tick();
        chk("t2_drained", out_valid, 0);

        // a = b with borrow-in, then signed overflow
        drive(64'd255, 64'd255, 1'b1);
        tick();
        drive(64'h8000_0000_0000_0000, 64'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3a_diff", diff, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3a_borrow", borrow_out, 1);
        chk("t3a_ovf", ovf, 0);
        tick();
        chk("t3b_valid", out_valid, 1);
        chk("t3b_diff", diff, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("t3b_borrow", borrow_out, 0);
        chk("t3b_ovf", ovf, 1);
        tick();
        chk("t3_drained", out_valid, 0);

        // Backpressure: three accepted, fourth refused, output held
        out_ready = 1'b0;
        drive(64'd10, 64'd1, 1'b0);
        #1 chk("t4_rdy0", in_ready, 1);
        tick();
        drive(64'd20, 64'd1, 1'b0);
        chk("t4_rdy1", in_ready, 1);
        tick();
        drive(64'd30, 64'd1, 1'b0);
        chk("t4_rdy2", in_ready, 1);
        tick();
        drive(64'd40, 64'd1, 1'b0);
        chk("t4_full_rdy", in_ready, 0);
        chk("t4_full_valid", out_valid, 1);
        chk("t4_full_diff", diff, 64'd9);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t4_hold_rdy", in_ready, 0);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_diff", diff, 64'd9);
        end
        out_ready = 1'b1;
        #1 chk("t4_release_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            chk("t4_drain_valid", out_valid, 1);
            chk("t4_drain_diff", diff, 64'(10 * (k + 1) - 1));
            tick();
        end
        chk("t4_drained", out_valid, 0);

        // Random streaming with random backpressure
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < 200 || exp_q.size() > 0) && cyc < 5000) begin
            in_valid  = (sent < 200) ? ($urandom_range(0, 3) != 0) : 1'b0;
            a         = {$urandom, $urandom};
            b         = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
            bin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_diff", diff, e[63:0]);
                    chk("stream_borrow", borrow_out, e[64]);
                    chk("stream_ovf", ovf, e[65]);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sub(a, b, bin));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_timeout", (cyc < 5000), 1);
        chk("stream_count", got, sent);

        // Reset mid-operation
        out_ready = 1'b1;
        drive(64'd100, 64'd1, 1'b0);
        tick();
        drive(64'd200, 64'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_diff", diff, 64'd99);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_diff", diff, 0);
        chk("t6_rst_borrow", borrow_out, 0);
        #2 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t6_stale", out_valid, 0);
            tick();
        end
        drive(64'd5, 64'd7, 1'b0);
        chk("t6_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t6_lat_a", out_valid, 0);
        tick();
        chk("t6_lat_b", out_valid, 0);
        tick();
        chk("t6_valid", out_valid, 1);
        chk("t6_diff", diff, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t6_borrow", borrow_out, 1);
        chk("t6_ovf", ovf, 0);
        tick();
        chk("t6_drained", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
